// File: rtl/max_int16_stream_if.sv
// ---------------------------------------------------------------------------
// max_int16_stream_if
// Element stream in, result stream out, for the signed-max reduction unit.
//
// Signals:
//   in_valid / in_ready   element handshake (transfer when both high)
//   in_data  [WIDTH]      signed operand
//   in_last               final element of the frame
//   out_valid / out_ready result handshake (transfer when both high)
//   out_max  [WIDTH]      signed maximum of the frame
//   out_idx  [CNT_W]      zero-based index of the first occurrence of the max
//   out_count[CNT_W]      element count, saturating
//   out_ovf               frame was longer than 2^CNT_W-1 elements
//
// Modports:
//   master  producer of elements / consumer of results
//   slave   the reduction unit itself
// ---------------------------------------------------------------------------
interface max_int16_stream_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [CNT_W-1:0] out_idx;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_max, out_idx, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_max, out_idx, out_count, out_ovf
   );

endinterface

// File: rtl/max_int16_stream.sv
// ---------------------------------------------------------------------------
// max_int16_stream
// Streaming signed-maximum reduction. A frame of signed WIDTH-bit elements
// arrives over a valid/ready stream terminated by in_last; one result per
// frame leaves over a valid/ready stream: maximum, index of its first
// occurrence, element count (saturating) and an overflow flag.
//
// Ports:
//   clk     single clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     max_int16_stream_if.slave (element and result streams)
//
// Also contains the comparator leaf cells it is built from:
//   subtractor_1bit_cmp  one-bit borrow-ripple subtractor cell
//   gt_int_nbit          signed a > b comparator
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// subtractor_1bit_cmp: diff = a - b - bin, with borrow out.
// Ports: a, b, bin (inputs), diff, bout (outputs).
// ---------------------------------------------------------------------------
module subtractor_1bit_cmp (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// ---------------------------------------------------------------------------
// gt_int_nbit: gt = (a > b), both operands two's complement.
// Ports: a, b [WIDTH] (inputs), gt (output).
// IMPL_TYPE 0 ripples b - a through subtractor_1bit_cmp cells; any other value
// uses a plain signed relational operator.
// ---------------------------------------------------------------------------
module gt_int_nbit #(
   parameter int WIDTH     = 16,
   parameter int IMPL_TYPE = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt
);

   generate
      if (IMPL_TYPE == 0) begin : g_ripple
         logic [WIDTH:0]   borrow_s;
         logic [WIDTH-2:0] diff_unused_s;
         logic             diff_msb_s;

         assign borrow_s[0] = 1'b0;

         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i == WIDTH - 1) begin : g_msb
               subtractor_1bit_cmp u_sub (
                  .a    (b[i]),
                  .b    (a[i]),
                  .bin  (borrow_s[i]),
                  .diff (diff_msb_s),
                  .bout (borrow_s[i+1])
               );
            end else begin : g_lo
               subtractor_1bit_cmp u_sub (
                  .a    (b[i]),
                  .b    (a[i]),
                  .bin  (borrow_s[i]),
                  .diff (diff_unused_s[i]),
                  .bout (borrow_s[i+1])
               );
            end
         end

         // b - a is negative exactly when a > b. The sign of the difference
         // is corrected by the signed-overflow term (borrow into the MSB
         // differing from borrow out of it).
         assign gt = diff_msb_s ^ borrow_s[WIDTH-1] ^ borrow_s[WIDTH];
      end else begin : g_behav
         assign gt = ($signed(a) > $signed(b));
      end
   endgenerate

endmodule

// ---------------------------------------------------------------------------
// max_int16_stream: top level of the reduction unit.
// ---------------------------------------------------------------------------
module max_int16_stream #(
   parameter int WIDTH     = 16,
   parameter int IMPL_TYPE = 0,
   parameter int CNT_W     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   max_int16_stream_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

   state_t           state_r;
   state_t           state_nxt_s;

   logic             in_ready_r;
   logic             out_valid_r;

   logic [WIDTH-1:0] acc_max_r;
   logic [WIDTH-1:0] acc_max_nxt_s;
   logic [CNT_W-1:0] acc_idx_r;
   logic [CNT_W-1:0] acc_idx_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             ovf_r;
   logic             ovf_nxt_s;

   logic [WIDTH-1:0] out_max_r;
   logic [CNT_W-1:0] out_idx_r;
   logic [CNT_W-1:0] out_count_r;
   logic             out_ovf_r;

   logic             in_xfer_s;
   logic             out_xfer_s;
   logic             gt_s;
   logic             cnt_sat_s;
   logic             load_result_s;
   logic             frame_start_s;

   assign in_xfer_s  = bus.in_valid & in_ready_r;
   assign out_xfer_s = out_valid_r & bus.out_ready;
   assign cnt_sat_s  = (cnt_r == CNT_MAX);

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_max   = out_max_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.out_count = out_count_r;
   assign bus.out_ovf   = out_ovf_r;

   // Signed compare of the incoming element against the running maximum.
   gt_int_nbit #(
      .WIDTH     (WIDTH),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_gt (
      .a  (bus.in_data),
      .b  (acc_max_r),
      .gt (gt_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and accumulator next values.
   always_comb begin
      state_nxt_s   = state_r;
      acc_max_nxt_s = acc_max_r;
      acc_idx_nxt_s = acc_idx_r;
      cnt_nxt_s     = cnt_r;
      ovf_nxt_s     = ovf_r;
      load_result_s = 1'b0;
      frame_start_s = 1'b0;

      case (state_r)
         IDLE: begin
            if (in_xfer_s) begin
               frame_start_s = 1'b1;
               acc_max_nxt_s = bus.in_data;
               acc_idx_nxt_s = CNT_ZERO;
               cnt_nxt_s     = CNT_ONE;
               ovf_nxt_s     = 1'b0;
               if (bus.in_last) begin
                  load_result_s = 1'b1;
                  state_nxt_s   = HOLD;
               end else begin
                  state_nxt_s   = ACCUM;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end

         ACCUM: begin
            if (in_xfer_s) begin
               // Strict greater-than: an equal value keeps the earlier index.
               if (gt_s) begin
                  acc_max_nxt_s = bus.in_data;
                  acc_idx_nxt_s = cnt_r;
               end else begin
                  acc_max_nxt_s = acc_max_r;
                  acc_idx_nxt_s = acc_idx_r;
               end
               // Count saturates; an increment attempted at the cap is sticky.
               if (cnt_sat_s) begin
                  cnt_nxt_s = cnt_r;
                  ovf_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
                  ovf_nxt_s = ovf_r;
               end
               if (bus.in_last) begin
                  load_result_s = 1'b1;
                  state_nxt_s   = HOLD;
               end else begin
                  state_nxt_s   = ACCUM;
               end
            end else begin
               state_nxt_s = ACCUM;
            end
         end

         HOLD: begin
            if (out_xfer_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end

         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Handshake flags are decoded from the next state so they are registered
   // and in_ready never depends combinationally on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= (state_nxt_s != HOLD);
         out_valid_r <= (state_nxt_s == HOLD);
      end
   end

   // Running accumulator for the frame in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_max_r <= DATA_ZERO;
         acc_idx_r <= CNT_ZERO;
         cnt_r     <= CNT_ZERO;
         ovf_r     <= 1'b0;
      end else begin
         acc_max_r <= acc_max_nxt_s;
         acc_idx_r <= acc_idx_nxt_s;
         cnt_r     <= cnt_nxt_s;
         ovf_r     <= ovf_nxt_s;
      end
   end

   // Result registers load on the edge that accepts the last element, so the
   // result already includes that element's comparison.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_max_r   <= DATA_ZERO;
         out_idx_r   <= CNT_ZERO;
         out_count_r <= CNT_ZERO;
         out_ovf_r   <= 1'b0;
      end else if (load_result_s) begin
         out_max_r   <= acc_max_nxt_s;
         out_idx_r   <= acc_idx_nxt_s;
         out_count_r <= cnt_nxt_s;
         out_ovf_r   <= ovf_nxt_s;
      end else if (frame_start_s) begin
         out_ovf_r   <= 1'b0;
      end else begin
         out_max_r   <= out_max_r;
         out_idx_r   <= out_idx_r;
         out_count_r <= out_count_r;
         out_ovf_r   <= out_ovf_r;
      end
   end

endmodule

// File: tb/tb_max_int16_stream.sv
// ---------------------------------------------------------------------------
// tb_max_int16_stream
// Drives the same element stream into two instances (CNT_W=8 and CNT_W=4)
// sharing out_ready; their handshakes are identical, only the count width
// differs. Expected results come from a frame-level model and are queued per
// instance; a monitor pops and compares whenever a result is presented.
// ---------------------------------------------------------------------------
module tb_max_int16_stream;

   typedef logic signed [15:0] sval_t;

   typedef struct {
      logic [15:0] mx;
      int          idx;
      int          cnt;
      bit          ovf;
      int          last_cyc;
   } exp_t;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        in_last   = 1'b0;
   logic [15:0] in_data   = 16'h0000;
   logic        out_ready = 1'b0;

   int    n_checks     = 0;
   int    n_fail       = 0;
   int    cyc          = 0;
   int    es           = 0;
   int    results_seen = 0;
   int    frames_sent  = 0;
   int    rdy_mode     = 0;
   int    last_xfer_cyc = 0;
   bit    pv [2];
   exp_t  q8 [$];
   exp_t  q4 [$];
   sval_t fr [$];

   max_int16_stream_if #(.WIDTH(16), .CNT_W(8)) bus8 ();
   max_int16_stream_if #(.WIDTH(16), .CNT_W(4)) bus4 ();

   assign bus8.in_valid  = in_valid;
   assign bus8.in_data   = in_data;
   assign bus8.in_last   = in_last;
   assign bus8.out_ready = out_ready;
   assign bus4.in_valid  = in_valid;
   assign bus4.in_data   = in_data;
   assign bus4.in_last   = in_last;
   assign bus4.out_ready = out_ready;

   max_int16_stream #(.WIDTH(16), .IMPL_TYPE(0), .CNT_W(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   max_int16_stream #(.WIDTH(16), .IMPL_TYPE(0), .CNT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   always #5 clk = ~clk;

   // cycle stamp, used for the result latency check
   always @(posedge clk) cyc <= cyc + 1;

   // edges seen since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) es <= 0;
      else if (es < 2) es <= es + 1;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // frame-level reference: max over the frame, then first position holding it
   function automatic exp_t model(input int cw);
      exp_t e;
      int   sat;
      int   best;
      int   first;
      int   n;
      sat   = (1 << cw) - 1;
      n     = fr.size();
      best  = -32768;
      first = -1;
      foreach (fr[i]) if (int'(fr[i]) > best) best = int'(fr[i]);
      foreach (fr[i]) if (first < 0 && int'(fr[i]) == best) first = i;
      e.mx       = 16'(best);
      e.idx      = (first < sat) ? first : sat;
      e.cnt      = (n < sat) ? n : sat;
      e.ovf      = (n > sat);
      e.last_cyc = 0;
      return e;
   endfunction

   task automatic mon(input int w, input logic ov, input logic ordy, input logic ir,
                      input logic [15:0] mx, input int idx, input int cnt, input logic ovf);
      exp_t  e;
      int    qs;
      string t;
      t  = (w == 0) ? "d8" : "d4";
      qs = (w == 0) ? q8.size() : q4.size();
      if (es >= 1) chk({t, "_in_ready_vs_out_valid"}, ir, !ov);
      if (ov) begin
         if (qs == 0) begin
            chk({t, "_unexpected_result_queue_size"}, qs, 1);
         end else begin
            e = (w == 0) ? q8[0] : q4[0];
            if (!pv[w]) chk({t, "_result_latency_cycle"}, cyc, e.last_cyc);
            chk({t, "_out_max"},   mx,  e.mx);
            chk({t, "_out_idx"},   idx, e.idx);
            chk({t, "_out_count"}, cnt, e.cnt);
            chk({t, "_out_ovf"},   ovf, e.ovf);
            if (ordy) begin
               if (w == 0) void'(q8.pop_front());
               else        void'(q4.pop_front());
               results_seen++;
            end
         end
      end
      pv[w] = ov;
   endtask

   // result monitor, samples on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv[0] = 1'b0;
            pv[1] = 1'b0;
         end else begin
            mon(0, bus8.out_valid, out_ready, bus8.in_ready, bus8.out_max,
                int'(bus8.out_idx), int'(bus8.out_count), bus8.out_ovf);
            mon(1, bus4.out_valid, out_ready, bus4.in_ready, bus4.out_max,
                int'(bus4.out_idx), int'(bus4.out_count), bus4.out_ovf);
            chk("in_ready_d4_eq_d8", bus4.in_ready, bus8.in_ready);
         end
      end
   end

   // out_ready driver: 0 = always ready, 1 = random, other = held low
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic apply_reset();
      in_valid = 1'b0;
      in_last  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_d8_out_valid", bus8.out_valid, 0);
      chk("rst_d8_in_ready",  bus8.in_ready,  0);
      chk("rst_d8_out_max",   bus8.out_max,   0);
      chk("rst_d8_out_idx",   bus8.out_idx,   0);
      chk("rst_d8_out_count", bus8.out_count, 0);
      chk("rst_d8_out_ovf",   bus8.out_ovf,   0);
      chk("rst_d4_out_valid", bus4.out_valid, 0);
      chk("rst_d4_in_ready",  bus4.in_ready,  0);
      @(posedge clk);
      @(posedge clk);
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_d8_in_ready",  bus8.in_ready,  1);
      chk("post_rst_d4_in_ready",  bus4.in_ready,  1);
      chk("post_rst_d8_out_valid", bus8.out_valid, 0);
   endtask

   task automatic send_elem(input sval_t d, input bit last, input bit gaps);
      int n;
      if (gaps) begin
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         repeat (n) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus8.in_ready && n < 400);
      if (!bus8.in_ready) chk("in_ready_timeout", bus8.in_ready, 1);
      last_xfer_cyc = cyc + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bit gaps);
      exp_t e;
      for (int i = 0; i < fr.size(); i++) send_elem(fr[i], (i == fr.size() - 1), gaps);
      in_valid = 1'b0;
      in_last  = 1'b0;
      e = model(8);
      e.last_cyc = last_xfer_cyc;
      q8.push_back(e);
      e = model(4);
      e.last_cyc = last_xfer_cyc;
      q4.push_back(e);
      frames_sent++;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q8.size() != 0 || q4.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_q8_left"}, q8.size(), 0);
      chk({name, "_q4_left"}, q4.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, results_seen=%0d expected %0d",
               results_seen, 2 * frames_sent);
      $fatal(1, "watchdog");
   end

   initial begin
      sval_t v;
      int    len;
      apply_reset();

      // basic frame
      fr = {16'sd3, -16'sd7, 16'sd12, 16'sd5};
      send_frame(1'b0);
      drain("basic");

      // signed extremes
      fr = {sval_t'(16'h8000), sval_t'(16'h7FFF), sval_t'(16'hFFFF)};
      send_frame(1'b0);
      drain("signed");

      // ties keep first occurrence
      fr = {16'sd9, 16'sd9, 16'sd4, 16'sd9};
      send_frame(1'b0);
      drain("ties");

      // single element with output backpressure
      rdy_mode = 2;
      @(posedge clk);
      #1;
      fr = {-16'sd1};
      send_frame(1'b0);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("hold_out_valid", bus8.out_valid, 1);
         chk("hold_in_ready",  bus8.in_ready,  0);
         chk("hold_out_max",   bus8.out_max,   16'hFFFF);
         @(negedge clk);
      end
      rdy_mode = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("release_out_valid", bus8.out_valid, 0);
      chk("release_in_ready",  bus8.in_ready,  1);
      drain("hold");

      // 17 ascending elements saturate the CNT_W=4 instance
      fr.delete();
      for (int i = 0; i <= 16; i++) fr.push_back(sval_t'(i));
      send_frame(1'b0);
      drain("saturate");

      // reset in the middle of a frame, then a fresh frame
      send_elem(16'sd5, 1'b0, 1'b0);
      send_elem(16'sd7, 1'b0, 1'b0);
      apply_reset();
      fr = {16'sd1, 16'sd2};
      send_frame(1'b0);
      drain("after_reset");

      // randomized frames with input gaps and output backpressure
      rdy_mode = 1;
      for (int f = 0; f < 1000; f++) begin
         len = $urandom_range(1, 20);
         fr.delete();
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 3))
               0: v = sval_t'($urandom_range(0, 6)) - 16'sd3;
               1: begin
                  case ($urandom_range(0, 3))
                     0:       v = sval_t'(16'h8000);
                     1:       v = sval_t'(16'h7FFF);
                     2:       v = sval_t'(16'hFFFF);
                     default: v = 16'sd0;
                  endcase
               end
               default: v = sval_t'($urandom_range(0, 65535));
            endcase
            fr.push_back(v);
         end
         send_frame(1'b1);
      end
      rdy_mode = 0;
      drain("random");

      chk("results_count", results_seen, 2 * frames_sent);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/max_int16_stream.md
Name: max_int16_stream

Overview:
- Streaming signed-maximum reduction unit, the max-side counterpart of the combinational signed min block.
- Accepts a frame of signed WIDTH-bit operands over a valid/ready input stream, delimited by a last flag.
- Emits one result per frame over a valid/ready output stream: the maximum value, the index of its first occurrence, and the element count.
- Sits downstream of bit-serial PIM compute tiles as a reduction stage. Compares through gt_int_nbit and subtractor_1bit_cmp.

Parameters:
- WIDTH, 16, operand width (two's complement).
- IMPL_TYPE, 0, passed unchanged to the gt_int_nbit instance.
- CNT_W, 8, width of the index and count fields.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept an element this cycle.
- in_data  input  WIDTH  signed operand.
- in_last  input  1  marks the final element of the frame.
- out_valid  output  1  result registers hold a completed frame.
- out_ready  input  1  downstream accepts the result.
- out_max  output  WIDTH  signed maximum of the frame.
- out_idx  output  CNT_W  zero-based index of the first occurrence of the max.
- out_count  output  CNT_W  number of elements in the frame (saturating).
- out_ovf  output  1  frame held more than 2^CNT_W-1 elements.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, applied asynchronously while rst_n=0:
  - State goes to IDLE.
  - out_valid=0, out_max=0, out_idx=0, out_count=0, out_ovf=0.
  - in_ready=0 during reset. After release, in_ready=1 from the first clock edge.
- Transfer rule: an element transfers when in_valid & in_ready at a rising edge. The result transfers when out_valid & out_ready.
- in_ready = (state != HOLD). It is a registered state decode, with no combinational path from out_ready.
- State machine:
  - IDLE: on transfer, acc_max<=in_data, acc_idx<=0, cnt<=1. If in_last, load the result registers and go to HOLD; else go to ACCUM.
  - ACCUM: on transfer, compute gt = (in_data > acc_max), signed, via gt_int_nbit(A=in_data, B=acc_max).
    - If gt: acc_max<=in_data and acc_idx<=cnt.
    - cnt<=cnt+1, saturating at 2^CNT_W-1. Set the sticky ovf flag if an increment is attempted at saturation.
    - If in_last: go to HOLD.
  - HOLD: out_valid=1. Result registers are stable until accepted. On out_ready, out_valid<=0 next cycle and go to IDLE.
  - No element is accepted in the cycle the result is accepted.
- Result loading:
  - Result registers load on the edge that accepts the in_last element.
  - The loaded result includes that element's comparison.
  - out_valid rises in the next cycle, giving one cycle of latency from the last transfer.
- Ties: strict greater-than, so the earliest index wins. Equal values never update acc_idx.
- Signedness: 0x8000 is the minimum and 0x7FFF the maximum. No unsigned compare anywhere.
- Index wrap: acc_idx takes cnt, so after saturation out_idx is capped at 2^CNT_W-1 and out_ovf=1 flags that it is unreliable.
- in_valid low in ACCUM: hold all state and wait indefinitely. There is no timeout.
- out_ready held low in HOLD: hold the result and keep in_ready=0. This backpressures upstream.
- Single-element frame (in_last on the first element): out_max=in_data, out_idx=0, out_count=1.
- Reset mid-frame: the partial frame is discarded and no result is emitted.
- out_ovf clears when a new frame starts in IDLE.

Test Plan:
- Frame {3, -7, 12, 5} (last on 5), out_ready=1 → out_valid one cycle after the last transfer; out_max=12, out_idx=2, out_count=4, out_ovf=0.
- Frame {0x8000, 0x7FFF, 0xFFFF} → out_max=0x7FFF, out_idx=1, out_count=3; checks the signed compare.
- Frame {9, 9, 4, 9} → out_max=9, out_idx=0; checks that ties keep the first occurrence.
- Single element -1 (0xFFFF) with in_last; hold out_ready=0 for 5 cycles:
  - out_valid stays 1, in_ready stays 0, and out_max=0xFFFF stays stable.
  - Release out_ready: next cycle out_valid=0, in_ready=1.
- CNT_W=4, frame of 17 elements ascending 0..16 → out_count=15, out_ovf=1, out_max=16.
- Assert rst_n=0 asynchronously after 2 elements of a frame, then send a fresh frame {1, 2} → only one result is produced: out_max=2, out_idx=1, out_count=2.
- Random in_valid/out_ready gaps over 1000 frames against a reference model → all results match and no element is lost or duplicated.
